test_pattern_sequencer: RTL and testbench
=========================================

// Module: test_pattern_sequencer
// PURPOSE
//  Holds eight test-pattern banks and a control word, all written over the PC bank port.
//  Streams a programmed sequence of those patterns into the LVDS transceiver TX path with a valid/ready handshake.
//  Reports progress back to the PC side through the 16-bit status bank.
//  Sits between the PC interface handler (bank side) and the transceiver TX input (stream side).
// PARAMETERS
//  TEST_PATTERN_WIDTH  56  width of one pattern bank and of the TX data word
// PORTS
//  i_clk        in   1   clock
//  i_arst_n     in   1   reset, asynchronous, active-low
//  i_bank_addr  in   3   bank address for writes and readback
//  i_bank_p     in   TPW pattern write data
//  i_bank_p_wr  in   1   1-cycle pattern write strobe
//  i_bank_c     in   16  control write data
//  i_bank_c_wr  in   1   1-cycle control write strobe
//  o_bank_l     out  TPW pattern readback, pattern[i_bank_addr], combinational
//  o_bank_s     out  16  status word, registered
//  o_tx_data    out  TPW TX pattern, registered
//  o_tx_valid   out  1   TX valid, registered
//  i_tx_rdy     in   1   TX ready; a beat transfers when o_tx_valid & i_tx_rdy
// BEHAVIOUR
//  Reset: all patterns 0, ctrl 0, o_tx_valid 0, o_tx_data 0, o_bank_s 0; state S_IDLE. Applies mid-run.
//  Pattern write:
//   - When i_bank_p_wr is high, pattern[i_bank_addr] <= i_bank_p; the new value is visible next cycle.
//   - Writes are allowed while running. A write to the bank being loaded in that same cycle yields the OLD value.
//  Control word, written only when i_bank_c_wr is high and i_bank_addr == 0 (other addresses ignored):
//   - [0] start: pulse, not stored.
//   - [1] stop: pulse, not stored.
//   - [2] loop.
//   - [5:3] last bank index L.
//   - [15:8] repeat count R. Each bank is sent R+1 times.
//   - Stored fields are sampled at start. Rewrites of [15:2] take effect on the next start only.
//  Status o_bank_s, updated every cycle:
//   - [0] busy (state != S_IDLE).
//   - [1] done (sticky; cleared on start).
//   - [2] stop_pending.
//   - [5:3] current bank index.
//   - [7:6] 0.
//   - [15:8] beat count: +1 per transfer, saturates at 255, cleared on start.
//  FSM S_IDLE, S_LOAD, S_SEND:
//   - S_IDLE: on start -> S_LOAD with idx=0, rep=0, done=0, beats=0. stop is ignored in this state.
//   - S_LOAD: o_tx_data <= pattern[idx], o_tx_valid <= 1 -> S_SEND. If stop_pending -> S_IDLE with valid 0.
//   - S_SEND: hold o_tx_data and o_tx_valid stable until transfer. On transfer:
//     - rep < R: rep+1, stay in S_SEND (back-to-back beats, no bubble).
//     - rep == R and idx < L: idx+1, rep=0 -> S_LOAD (one-cycle bubble per bank change).
//     - rep == R and idx == L and loop: idx=0 -> S_LOAD.
//     - rep == R and idx == L and not loop: done=1 -> S_IDLE, o_tx_valid 0 next cycle.
//     - stop_pending at transfer: -> S_IDLE, clear stop_pending, done stays 0.
//   - Stop while busy: sets stop_pending. Valid is never withdrawn before a transfer.
//   - Start while busy: ignored. Start and stop in the same write: stop wins (idle: no run).
//  Latency: start write at cycle T gives o_tx_valid=1 at T+2 (T+1 S_IDLE->S_LOAD, T+2 S_SEND).
//  Width: idx 3 bits; L=7 covers all banks; L=0 sends bank 0 only. rep is 8 bits; R=255 sends 256 beats.
// TESTING
//  1 Patterns 0..2 = 0x11..,0x22..,0x33..; ctrl L=2,R=1,start; rdy=1 -> beats 11,11,22,22,33,33; then busy 0, done 1, beats 6.
//  2 As 1 but rdy toggles 1/0 -> o_tx_data and o_tx_valid stay stable while rdy=0; same 6-beat order; no lost or duplicated beats.
//  3 loop=1, L=1, R=0; stop after 5 beats -> beat 6 completes, then valid 0, busy 0, done 0, stop_pending 0.
//  4 Run L=7, R=3; write bank 5 = 0xAA.. while sending bank 2 -> bank 5 transmits 0xAA.. x4; o_bank_l readback matches.
//  5 Assert i_arst_n low mid-beat, then release -> all outputs 0, state idle; new start replays from bank 0 with patterns at 0.
//  6 Start while busy, and start+stop from idle -> no restart, no run; beat count and done unchanged.

Source files
------------

// File: rtl/test_pattern_sequencer_if.sv
// Bank-port and TX-stream signals of the test pattern sequencer.
// The master side is the PC bank handler plus the TX sink (which drives
// rdy); the slave side is the sequencer itself.
interface test_pattern_sequencer_if #(
   parameter int TPW = 56
);
   // PC bank port
   logic [2:0]     bank_addr;
   logic [TPW-1:0] bank_p;
   logic           bank_p_wr;
   logic [15:0]    bank_c;
   logic           bank_c_wr;
   logic [TPW-1:0] bank_l;
   logic [15:0]    bank_s;

   // TX stream
   logic [TPW-1:0] tx_data;
   logic           tx_valid;
   logic           tx_rdy;

   modport master (
      output bank_addr, bank_p, bank_p_wr, bank_c, bank_c_wr, tx_rdy,
      input  bank_l, bank_s, tx_data, tx_valid
   );

   modport slave (
      input  bank_addr, bank_p, bank_p_wr, bank_c, bank_c_wr, tx_rdy,
      output bank_l, bank_s, tx_data, tx_valid
   );
endinterface

// File: rtl/test_pattern_sequencer.sv
// Test pattern sequencer: eight pattern banks written from the PC side,
// streamed out to the LVDS TX path as a programmed sequence with a
// valid/ready handshake, with progress reported in a 16-bit status word.
module test_pattern_sequencer #(
   parameter int TEST_PATTERN_WIDTH = 56
) (
   input logic                     i_clk,
   input logic                     i_arst_n,
   test_pattern_sequencer_if.slave bus
);
   localparam int TPW = TEST_PATTERN_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t         state_reg, state_next;

   logic [TPW-1:0] pattern_reg [8];
   logic [7:0]     bank_we;

   logic           ctrl_wr;
   logic           start_cmd;
   logic           stop_cmd;
   logic           xfer;

   logic [2:0]     idx_reg, idx_next;
   logic [7:0]     rep_reg, rep_next;
   logic           done_reg, done_next;
   logic           stop_pending_reg, stop_pending_next;
   logic [7:0]     beats_reg, beats_next;

   // Run configuration, captured from the control word that carries start.
   // Every control write carries the whole word, so the start write itself
   // holds the fields for the run; later rewrites only matter at the next start.
   logic           run_loop_reg, run_loop_next;
   logic [2:0]     run_last_reg, run_last_next;
   logic [7:0]     run_rep_reg, run_rep_next;

   logic [TPW-1:0] tx_data_reg, tx_data_next;
   logic           tx_valid_reg, tx_valid_next;
   logic [15:0]    status_reg, status_next;

   // Control bits [7:6] carry no function.
   logic           unused_ctrl_bits;
   assign unused_ctrl_bits = ^bus.bank_c[7:6];

   // Control decode: only address 0 accepts control; stop overrides start.
   assign ctrl_wr   = bus.bank_c_wr && (bus.bank_addr == 3'd0);
   assign stop_cmd  = ctrl_wr && bus.bank_c[1];
   assign start_cmd = ctrl_wr && bus.bank_c[0] && !bus.bank_c[1];
   assign xfer      = tx_valid_reg && bus.tx_rdy;

   // Per-bank write enables.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bank_we
         assign bank_we[gi] = bus.bank_p_wr && (bus.bank_addr == 3'(gi));
      end
   endgenerate

   // Pattern banks; a write lands at the edge, so a same-cycle load sees the old value.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         for (int i = 0; i < 8; i++) pattern_reg[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (bank_we[i]) pattern_reg[i] <= bus.bank_p;
         end
      end
   end

   assign bus.bank_l = pattern_reg[bus.bank_addr];

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) state_reg <= S_IDLE;
      else           state_reg <= state_next;
   end

   // Sequencing counters, flags and run configuration registers.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         idx_reg          <= '0;
         rep_reg          <= '0;
         done_reg         <= 1'b0;
         stop_pending_reg <= 1'b0;
         beats_reg        <= '0;
         run_loop_reg     <= 1'b0;
         run_last_reg     <= '0;
         run_rep_reg      <= '0;
      end else begin
         idx_reg          <= idx_next;
         rep_reg          <= rep_next;
         done_reg         <= done_next;
         stop_pending_reg <= stop_pending_next;
         beats_reg        <= beats_next;
         run_loop_reg     <= run_loop_next;
         run_last_reg     <= run_last_next;
         run_rep_reg      <= run_rep_next;
      end
   end

   // Next-state logic: walk banks idx 0..L, each sent R+1 times.
   always_comb begin
      state_next        = state_reg;
      idx_next          = idx_reg;
      rep_next          = rep_reg;
      done_next         = done_reg;
      stop_pending_next = stop_pending_reg;
      beats_next        = beats_reg;
      run_loop_next     = run_loop_reg;
      run_last_next     = run_last_reg;
      run_rep_next      = run_rep_reg;

      if (xfer && (beats_reg != 8'hFF)) beats_next = beats_reg + 8'd1;

      case (state_reg)
         S_IDLE: begin
            if (start_cmd) begin
               state_next    = S_LOAD;
               idx_next      = '0;
               rep_next      = '0;
               done_next     = 1'b0;
               beats_next    = '0;
               run_loop_next = bus.bank_c[2];
               run_last_next = bus.bank_c[5:3];
               run_rep_next  = bus.bank_c[15:8];
            end
         end
         S_LOAD: begin
            if (stop_pending_reg) state_next = S_IDLE;
            else                  state_next = S_SEND;
         end
         S_SEND: begin
            if (xfer) begin
               if (stop_pending_reg) begin
                  state_next = S_IDLE;
               end else if (rep_reg < run_rep_reg) begin
                  rep_next = rep_reg + 8'd1;
               end else if (idx_reg < run_last_reg) begin
                  idx_next   = idx_reg + 3'd1;
                  rep_next   = '0;
                  state_next = S_LOAD;
               end else if (run_loop_reg) begin
                  idx_next   = '0;
                  rep_next   = '0;
                  state_next = S_LOAD;
               end else begin
                  done_next  = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase

      // A pending stop lives only while busy; any return to idle clears it.
      if (state_next == S_IDLE)
         stop_pending_next = 1'b0;
      else if (stop_cmd && (state_reg != S_IDLE))
         stop_pending_next = 1'b1;
   end

   // Output logic: load the beat in S_LOAD, hold it through stalls, drop valid on leaving S_SEND.
   always_comb begin
      tx_data_next  = tx_data_reg;
      tx_valid_next = tx_valid_reg;

      case (state_reg)
         S_IDLE: tx_valid_next = 1'b0;
         S_LOAD: begin
            if (stop_pending_reg) begin
               tx_valid_next = 1'b0;
            end else begin
               tx_data_next  = pattern_reg[idx_reg];
               tx_valid_next = 1'b1;
            end
         end
         S_SEND: begin
            if (xfer && (state_next != S_SEND)) tx_valid_next = 1'b0;
         end
         default: tx_valid_next = 1'b0;
      endcase

      // Status tracks the state being entered so it lines up with the FSM.
      status_next = {beats_next, 2'b00, idx_next, stop_pending_next,
                     done_next, (state_next != S_IDLE)};
   end

   // Registered TX and status outputs.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
         status_reg   <= '0;
      end else begin
         tx_data_reg  <= tx_data_next;
         tx_valid_reg <= tx_valid_next;
         status_reg   <= status_next;
      end
   end

   assign bus.tx_data  = tx_data_reg;
   assign bus.tx_valid = tx_valid_reg;
   assign bus.bank_s   = status_reg;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Directed testbench for test_pattern_sequencer.
module tb_test_pattern_sequencer;
   localparam int W = 56;

   logic clk    = 1'b0;
   logic arst_n = 1'b0;
   int   tests  = 0;
   int   fails  = 0;

   logic [W-1:0] q [$];

   always #5 clk = ~clk;

   test_pattern_sequencer_if #(.TPW(W)) bus ();

   test_pattern_sequencer #(.TEST_PATTERN_WIDTH(W)) dut (
      .i_clk    (clk),
      .i_arst_n (arst_n),
      .bus      (bus)
   );

   // Record every completed beat
   always @(posedge clk) begin
      if (arst_n && bus.tx_valid && bus.tx_rdy) q.push_back(bus.tx_data);
   end

   function automatic logic [W-1:0] pat(input logic [7:0] b);
      return {7{b}};
   endfunction

   function automatic logic [15:0] cw(input logic [7:0] r, input logic [2:0] l,
                                      input logic lp, input logic stp, input logic st);
      return {r, 2'b00, l, lp, stp, st};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pat(input logic [2:0] a, input logic [W-1:0] v);
      bus.bank_addr = a;
      bus.bank_p    = v;
      bus.bank_p_wr = 1'b1;
      tick();
      bus.bank_p_wr = 1'b0;
   endtask

   task automatic write_ctrl(input logic [15:0] v);
      bus.bank_addr = 3'd0;
      bus.bank_c    = v;
      bus.bank_c_wr = 1'b1;
      tick();
      bus.bank_c_wr = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (bus.bank_s[0] && n < budget) begin
         tick();
         n++;
      end
      tests++;
      if (bus.bank_s[0] !== 1'b0) begin
         fails++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, bus.bank_s[0], budget);
      end
   endtask

   task automatic test_reset();
      bus.bank_addr = 3'd0;
      bus.bank_p = '0;
      bus.bank_p_wr = 1'b0;
      bus.bank_c = '0;
      bus.bank_c_wr = 1'b0;
      bus.tx_rdy = 1'b0;
      #12;
      tests++;
      if (bus.tx_valid !== 1'b0 || bus.tx_data !== '0) begin
         fails++; $display("FAIL reset_tx: valid=%b data=%h, required 0/0", bus.tx_valid, bus.tx_data);
      end
      tests++;
      if (bus.bank_s !== 16'h0000 || bus.bank_l !== '0) begin
         fails++; $display("FAIL reset_bank: status=%h readback=%h, required 0/0", bus.bank_s, bus.bank_l);
      end
      tick();
      arst_n = 1'b1;
      tick();
      tests++;
      if (bus.bank_s !== 16'h0000 || bus.tx_valid !== 1'b0) begin
         fails++; $display("FAIL reset_release: status=%h valid=%b, required 0000/0", bus.bank_s, bus.tx_valid);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_basic();
      logic [7:0] eb [6];
      eb = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
      write_pat(3'd0, pat(8'h11));
      write_pat(3'd1, pat(8'h22));
      write_pat(3'd2, pat(8'h33));
      bus.tx_rdy = 1'b1;
      q.delete();
      write_ctrl(cw(8'd1, 3'd2, 1'b0, 1'b0, 1'b1));
      tests++;
      if (bus.tx_valid !== 1'b0 || bus.bank_s[0] !== 1'b1) begin
         fails++; $display("FAIL basic_latency1: valid=%b busy=%b, required 0/1", bus.tx_valid, bus.bank_s[0]);
      end
      tick();
      tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== pat(8'h11)) begin
         fails++; $display("FAIL basic_latency2: valid=%b data=%h, required 1/%h", bus.tx_valid, bus.tx_data, pat(8'h11));
      end
      wait_idle(50, "basic");
      tests++;
      if (q.size() != 6) begin
         fails++; $display("FAIL basic_count: got %0d beats, required 6", q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            tests++;
            if (q[i] !== pat(eb[i])) begin
               fails++; $display("FAIL basic_beat%0d: got %h, required %h", i, q[i], pat(eb[i]));
            end
         end
      end
      tests++;
      if (bus.bank_s[1:0] !== 2'b10 || bus.bank_s[15:8] !== 8'd6 || bus.tx_valid !== 1'b0) begin
         fails++; $display("FAIL basic_status: status=%h valid=%b, required busy0 done1 beats6 valid0", bus.bank_s, bus.tx_valid);
      end
      $display("[TB] test_basic done, %0d beats", q.size());
   endtask

   task automatic test_backpressure();
      logic [7:0]   eb [6];
      logic         pv, pr;
      logic [W-1:0] pd;
      int           n = 0;
      eb = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
      q.delete();
      bus.tx_rdy = 1'b0;
      write_ctrl(cw(8'd1, 3'd2, 1'b0, 1'b0, 1'b1));
      while (bus.bank_s[0] && n < 200) begin
         pv = bus.tx_valid;
         pd = bus.tx_data;
         pr = bus.tx_rdy;
         tick();
         n++;
         if (pv && !pr) begin
            tests++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== pd) begin
               fails++; $display("FAIL bp_stable: valid=%b data=%h, required 1/%h", bus.tx_valid, bus.tx_data, pd);
            end
         end
         bus.tx_rdy = ~bus.tx_rdy;
      end
      bus.tx_rdy = 1'b1;
      wait_idle(10, "bp");
      tests++;
      if (q.size() != 6) begin
         fails++; $display("FAIL bp_count: got %0d beats, required 6", q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            tests++;
            if (q[i] !== pat(eb[i])) begin
               fails++; $display("FAIL bp_beat%0d: got %h, required %h", i, q[i], pat(eb[i]));
            end
         end
      end
      tests++;
      if (bus.bank_s[1:0] !== 2'b10 || bus.bank_s[15:8] !== 8'd6) begin
         fails++; $display("FAIL bp_status: status=%h, required done1 busy0 beats6", bus.bank_s);
      end
      $display("[TB] test_backpressure done, %0d beats", q.size());
   endtask

   task automatic test_stop();
      int n = 0;
      q.delete();
      bus.tx_rdy = 1'b1;
      write_ctrl(cw(8'd0, 3'd1, 1'b1, 1'b0, 1'b1));
      while (q.size() < 5 && n < 100) begin
         tick();
         n++;
      end
      tests++;
      if (q.size() != 5) begin
         fails++; $display("FAIL stop_reach5: got %0d beats, required 5", q.size());
      end
      bus.tx_rdy = 1'b0;
      write_ctrl(cw(8'd0, 3'd1, 1'b1, 1'b1, 1'b0));
      tick();
      tick();
      tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== pat(8'h22) || bus.bank_s[2:0] !== 3'b101) begin
         fails++; $display("FAIL stop_pending: valid=%b data=%h status=%h, required 1/%h pend1 busy1",
                           bus.tx_valid, bus.tx_data, bus.bank_s, pat(8'h22));
      end
      bus.tx_rdy = 1'b1;
      wait_idle(20, "stop");
      tick();
      tests++;
      if (q.size() != 6 || q[q.size()-1] !== pat(8'h22)) begin
         fails++; $display("FAIL stop_beats: got %0d beats last=%h, required 6 last=%h", q.size(), q[q.size()-1], pat(8'h22));
      end
      tests++;
      if (bus.tx_valid !== 1'b0 || bus.bank_s[2:0] !== 3'b000 || bus.bank_s[15:8] !== 8'd6) begin
         fails++; $display("FAIL stop_status: valid=%b status=%h, required 0, flags 000 beats6", bus.tx_valid, bus.bank_s);
      end
      $display("[TB] test_stop done, %0d beats", q.size());
   endtask

   task automatic test_live_write();
      int         n = 0;
      logic [7:0] b;
      for (int i = 0; i < 8; i++) write_pat(3'(i), pat(8'((i + 1) * 17)));
      q.delete();
      bus.tx_rdy = 1'b1;
      write_ctrl(cw(8'd3, 3'd7, 1'b0, 1'b0, 1'b1));
      while (bus.bank_s[5:3] != 3'd2 && n < 100) begin
         tick();
         n++;
      end
      tests++;
      if (bus.bank_s[5:3] !== 3'd2) begin
         fails++; $display("FAIL live_reach2: idx=%0d, required 2", bus.bank_s[5:3]);
      end
      write_pat(3'd5, pat(8'hAA));
      wait_idle(200, "live");
      tests++;
      if (q.size() != 32) begin
         fails++; $display("FAIL live_count: got %0d beats, required 32", q.size());
      end else begin
         for (int k = 0; k < 32; k++) begin
            b = (k / 4 == 5) ? 8'hAA : 8'((k / 4 + 1) * 17);
            tests++;
            if (q[k] !== pat(b)) begin
               fails++; $display("FAIL live_beat%0d: got %h, required %h", k, q[k], pat(b));
            end
         end
      end
      bus.bank_addr = 3'd5;
      #1;
      tests++;
      if (bus.bank_l !== pat(8'hAA)) begin
         fails++; $display("FAIL live_readback: got %h, required %h", bus.bank_l, pat(8'hAA));
      end
      tests++;
      if (bus.bank_s[1:0] !== 2'b10 || bus.bank_s[15:8] !== 8'd32) begin
         fails++; $display("FAIL live_status: status=%h, required done1 busy0 beats32", bus.bank_s);
      end
      $display("[TB] test_live_write done, %0d beats", q.size());
   endtask

   task automatic test_saturate();
      q.delete();
      bus.tx_rdy = 1'b1;
      write_ctrl(cw(8'd255, 3'd0, 1'b0, 1'b0, 1'b1));
      wait_idle(400, "sat");
      tests++;
      if (q.size() != 256) begin
         fails++; $display("FAIL sat_count: got %0d beats, required 256", q.size());
      end else begin
         tests++;
         if (q[0] !== pat(8'h11) || q[255] !== pat(8'h11)) begin
            fails++; $display("FAIL sat_data: first=%h last=%h, required %h", q[0], q[255], pat(8'h11));
         end
      end
      tests++;
      if (bus.bank_s[15:8] !== 8'd255 || bus.bank_s[1:0] !== 2'b10) begin
         fails++; $display("FAIL sat_status: status=%h, required beats255 done1 busy0", bus.bank_s);
      end
      $display("[TB] test_saturate done, %0d beats", q.size());
   endtask

   task automatic test_async_reset();
      bus.tx_rdy = 1'b0;
      write_ctrl(cw(8'd3, 3'd7, 1'b0, 1'b0, 1'b1));
      tick();
      tests++;
      if (bus.tx_valid !== 1'b1) begin
         fails++; $display("FAIL areset_pre: valid=%b, required 1", bus.tx_valid);
      end
      bus.bank_addr = 3'd5;
      #3;
      arst_n = 1'b0;
      #1;
      tests++;
      if (bus.tx_valid !== 1'b0 || bus.tx_data !== '0 || bus.bank_s !== 16'h0000) begin
         fails++; $display("FAIL areset_out: valid=%b data=%h status=%h, required all 0", bus.tx_valid, bus.tx_data, bus.bank_s);
      end
      tests++;
      if (bus.bank_l !== '0) begin
         fails++; $display("FAIL areset_pattern: got %h, required 0", bus.bank_l);
      end
      tick();
      tick();
      arst_n = 1'b1;
      tick();
      tests++;
      if (bus.bank_s !== 16'h0000 || bus.tx_valid !== 1'b0) begin
         fails++; $display("FAIL areset_idle: status=%h valid=%b, required 0/0", bus.bank_s, bus.tx_valid);
      end
      q.delete();
      bus.tx_rdy = 1'b1;
      write_ctrl(cw(8'd0, 3'd0, 1'b0, 1'b0, 1'b1));
      wait_idle(20, "areset");
      tests++;
      if (q.size() != 1 || q[0] !== '0 || bus.bank_s[1] !== 1'b1) begin
         fails++; $display("FAIL areset_replay: beats=%0d data=%h done=%b, required 1/0/1", q.size(), q[0], bus.bank_s[1]);
      end
      $display("[TB] test_async_reset done");
   endtask

   task automatic test_start_busy();
      logic [7:0] eb [4];
      eb = '{8'h5A, 8'h5A, 8'hA5, 8'hA5};
      write_pat(3'd0, pat(8'h5A));
      write_pat(3'd1, pat(8'hA5));
      q.delete();
      bus.tx_rdy = 1'b1;
      write_ctrl(cw(8'd1, 3'd1, 1'b0, 1'b0, 1'b1));
      tick();
      write_ctrl(cw(8'd0, 3'd0, 1'b0, 1'b0, 1'b1));
      wait_idle(50, "busy");
      tests++;
      if (q.size() != 4) begin
         fails++; $display("FAIL busy_count: got %0d beats, required 4", q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (q[i] !== pat(eb[i])) begin
               fails++; $display("FAIL busy_beat%0d: got %h, required %h", i, q[i], pat(eb[i]));
            end
         end
      end
      tests++;
      if (bus.bank_s[15:8] !== 8'd4 || bus.bank_s[1:0] !== 2'b10) begin
         fails++; $display("FAIL busy_status: status=%h, required beats4 done1 busy0", bus.bank_s);
      end
      write_ctrl(cw(8'd0, 3'd0, 1'b0, 1'b1, 1'b1));
      tick();
      tick();
      tick();
      tests++;
      if (bus.bank_s[2:0] !== 3'b010 || bus.bank_s[15:8] !== 8'd4 || bus.tx_valid !== 1'b0 || q.size() != 4) begin
         fails++; $display("FAIL startstop_idle: status=%h valid=%b beats=%0d, required done1 busy0 beats4 valid0 4",
                           bus.bank_s, bus.tx_valid, q.size());
      end
      $display("[TB] test_start_busy done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_stop();
      test_live_write();
      test_saturate();
      test_async_reset();
      test_start_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
